uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one uart_tx instance between NUM_REQ byte producers.
- Accepts one byte from the winning requester and waits for the transmitter to go idle.
- Issues a single-cycle data-valid strobe to uart_tx, then waits for its done pulse.
- Enforces a minimum idle gap before the next arbitration.
- Sits between application logic (status reporters, debug taps) and uart_tx, and replaces ad-hoc per-design TX state machines.

---
 rtl/uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx between NUM_REQ byte producers. A round-robin scan picks
// a requester, captures its byte (req_ack pulse), waits for the transmitter
// to go idle, strobes tx_dv for one cycle, waits for tx_done, then
// optionally idles GAP_CLKS cycles before arbitrating again.
//
// Optional feature macro: UART_TAG_EN
//   When defined, each granted byte is preceded by a tag byte
//   TAG_BASE + grant_id, sent with the same ready/strobe/done handshake.
//
// Handshake with uart_tx: tx_dv is a one-cycle strobe that is only raised
// while tx_active was seen low; after the strobe the block waits for the
// one-cycle tx_done pulse. tx_done outside a WAIT_DONE state is ignored.
// Requester side: req_valid is a level; the byte must be stable while it is
// high; req_ack pulses for one cycle in the cycle after the grant edge.
//
// Ports:
//   CLK_50     in   system clock
//   RST        in   asynchronous reset, active-high
//   req_valid  in   [NUM_REQ]   per-requester byte-available level
//   req_byte   in   [8*NUM_REQ] packed bytes, requester i on [8i+7:8i]
//   req_ack    out  [NUM_REQ]   one-cycle capture pulse
//   grant_id   out  [3]         requester being served
//   busy       out              high in every state except IDLE
//   tx_dv      out              to uart_tx i_TX_DV
//   tx_byte    out  [8]         to uart_tx i_TX_Byte
//   tx_active  in               from uart_tx o_TX_Active
//   tx_done    in               from uart_tx o_TX_Done
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          GAP_CLKS = 0,
    parameter logic [7:0]  TAG_BASE = 8'h30
) (
    input  logic                   CLK_50,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_byte,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   tx_dv,
    output logic [7:0]             tx_byte,
    input  logic                   tx_active,
    input  logic                   tx_done
);

    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (GAP_CLKS < 0) begin : g_bad_gap
        $error("uart_tx_arbiter: GAP_CLKS must be non-negative");
    end
    if ((int'(TAG_BASE) + NUM_REQ) > 256) begin : g_bad_tag
        $error("uart_tx_arbiter: TAG_BASE + NUM_REQ - 1 overflows a byte");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_START,
        S_WAIT_DONE,
        S_GAP
`ifdef UART_TAG_EN
        ,
        S_TAG_WAIT_READY,
        S_TAG_START,
        S_TAG_WAIT_DONE
`endif
    } state_t;

    state_t               r_state;
    logic [2:0]           r_rr_ptr;
    logic [GW-1:0]        r_gap_cnt;
    logic [NUM_REQ-1:0]   r_req_ack;
    logic                 r_tx_dv;
    logic [7:0]           r_tx_byte;
    logic [2:0]           r_grant_id;
    logic                 r_busy;
`ifdef UART_TAG_EN
    logic [7:0]           r_data_byte;
    logic [7:0]           w_data_nxt;
`endif

    state_t               w_state_nxt;
    logic [2:0]           w_rr_nxt;
    logic [GW-1:0]        w_gap_nxt;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic                 w_dv_nxt;
    logic [7:0]           w_byte_nxt;
    logic [2:0]           w_gid_nxt;
    logic                 w_found;
    logic [2:0]           w_win;
    logic [7:0]           w_win_byte;

    // (base + off) mod NUM_REQ for base, off < NUM_REQ.
    function automatic logic [2:0] rr_add(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 4'(NUM_REQ)) s = s - 4'(NUM_REQ);
        return s[2:0];
    endfunction

    // Round-robin winner: walk offsets from the largest down so the
    // smallest offset from r_rr_ptr is the last (and final) assignment.
    always_comb begin
        w_found    = 1'b0;
        w_win      = 3'd0;
        w_win_byte = 8'h00;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (rr_add(r_rr_ptr, 3'(k)) == 3'(i))) begin
                    w_found = 1'b1;
                    w_win   = 3'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == 3'(i)) w_win_byte = req_byte[8*i +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_gap_nxt   = r_gap_cnt;
        w_ack_nxt   = '0;
        w_dv_nxt    = 1'b0;
        w_byte_nxt  = r_tx_byte;
        w_gid_nxt   = r_grant_id;
`ifdef UART_TAG_EN
        w_data_nxt  = r_data_byte;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        w_ack_nxt[i] = (w_win == 3'(i));
                    end
                    w_gid_nxt = w_win;
`ifdef UART_TAG_EN
                    w_data_nxt  = w_win_byte;
                    w_byte_nxt  = TAG_BASE + {5'd0, w_win};
                    w_state_nxt = S_TAG_WAIT_READY;
`else
                    w_byte_nxt  = w_win_byte;
                    w_state_nxt = S_WAIT_READY;
`endif
                end
            end
`ifdef UART_TAG_EN
            S_TAG_WAIT_READY: begin
                if (!tx_active) w_state_nxt = S_TAG_START;
            end
            S_TAG_START: begin
                w_dv_nxt    = 1'b1;
                w_state_nxt = S_TAG_WAIT_DONE;
            end
            S_TAG_WAIT_DONE: begin
                // Swap in the data byte only once the tag has gone out.
                if (tx_done) begin
                    w_byte_nxt  = r_data_byte;
                    w_state_nxt = S_WAIT_READY;
                end
            end
`endif
            S_WAIT_READY: begin
                if (!tx_active) w_state_nxt = S_START;
            end
            S_START: begin
                w_dv_nxt    = 1'b1;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    w_rr_nxt    = (r_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
                    w_gap_nxt   = '0;
                    w_state_nxt = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + GW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 3'd0;
            r_gap_cnt  <= '0;
            r_req_ack  <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_grant_id <= 3'd0;
            r_busy     <= 1'b0;
`ifdef UART_TAG_EN
            r_data_byte <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_req_ack  <= w_ack_nxt;
            r_tx_dv    <= w_dv_nxt;
            r_tx_byte  <= w_byte_nxt;
            r_grant_id <= w_gid_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
`ifdef UART_TAG_EN
            r_data_byte <= w_data_nxt;
`endif
        end
    end

    assign req_ack  = r_req_ack;
    assign tx_dv    = r_tx_dv;
    assign tx_byte  = r_tx_byte;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. A table of {req_valid, req_byte,
// expected grant, expected byte} records drives a sequence of grants whose
// round-robin order was worked out by hand; hand-written sequences cover a
// busy transmitter, stray tx_done, the idle gap (second instance with
// GAP_CLKS=5) and an asynchronous reset in the middle of a byte.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam logic [7:0] TAG_BASE = 8'h30;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_byte;
    logic [3:0]  req_ack;
    logic [2:0]  grant_id;
    logic        busy;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;

    logic [3:0]  g_req_valid;
    logic [31:0] g_req_byte;
    logic [3:0]  g_req_ack;
    logic [2:0]  g_grant_id;
    logic        g_busy;
    logic        g_tx_dv;
    logic [7:0]  g_tx_byte;
    logic        g_tx_active;
    logic        g_tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .TAG_BASE(TAG_BASE)) dut (
        .CLK_50(clk), .RST(rst),
        .req_valid(req_valid), .req_byte(req_byte), .req_ack(req_ack),
        .grant_id(grant_id), .busy(busy), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .tx_active(tx_active), .tx_done(tx_done)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(5), .TAG_BASE(TAG_BASE)) dut_gap (
        .CLK_50(clk), .RST(rst),
        .req_valid(g_req_valid), .req_byte(g_req_byte), .req_ack(g_req_ack),
        .grant_id(g_grant_id), .busy(g_busy), .tx_dv(g_tx_dv), .tx_byte(g_tx_byte),
        .tx_active(g_tx_active), .tx_done(g_tx_done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] rb;
        logic [2:0]  id;
        logic [7:0]  byt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts falling edges until tx_dv is seen (bounded).
    task automatic wait_dv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_dv && n < 50);
    endtask

    // Checks the strobe is one cycle wide, then returns a tx_done pulse.
    task automatic finish_byte(input string name);
        @(negedge clk);
        chk({name, " dv single"}, 32'(tx_dv), 32'd0);
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // One complete grant on the main instance, starting from IDLE.
    task automatic do_txn(input logic [3:0] rv, input logic [31:0] rb,
                          input logic [2:0] id, input logic [7:0] b, input string name);
        int n;
        @(negedge clk);
        req_valid = rv;
        req_byte  = rb;
        @(negedge clk);
        chk({name, " ack"},   32'(req_ack),  32'(4'b0001 << id));
        chk({name, " gid"},   32'(grant_id), 32'(id));
        chk({name, " busy1"}, 32'(busy),     32'd1);
        req_valid = 4'b0000;
`ifdef UART_TAG_EN
        wait_dv(n);
        chk({name, " tag lat"},  32'(n),       32'd2);
        chk({name, " tag byte"}, 32'(tx_byte), 32'(TAG_BASE + {5'd0, id}));
        finish_byte({name, " tag"});
`endif
        wait_dv(n);
        chk({name, " lat"},    32'(n),        32'd2);
        chk({name, " byte"},   32'(tx_byte),  32'(b));
        chk({name, " ack0"},   32'(req_ack),  32'd0);
        chk({name, " gid st"}, 32'(grant_id), 32'(id));
        finish_byte(name);
        chk({name, " busy0"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        logic dv_seen;

        // Expected grants from rr_ptr=0 after reset.
        vecs[0] = '{4'b1111, 32'hA3A2_A1A0, 3'd0, 8'hA0};
        vecs[1] = '{4'b1111, 32'hA3A2_A1A0, 3'd1, 8'hA1};
        vecs[2] = '{4'b1111, 32'hA3A2_A1A0, 3'd2, 8'hA2};
        vecs[3] = '{4'b1111, 32'hA3A2_A1A0, 3'd3, 8'hA3};
        vecs[4] = '{4'b1111, 32'hA3A2_A1A0, 3'd0, 8'hA0};  // ptr 0 -> wraps
        vecs[5] = '{4'b0100, 32'h0046_0000, 3'd2, 8'h46};  // ptr 1
        vecs[6] = '{4'b0011, 32'h0000_2211, 3'd0, 8'h11};  // ptr 3, wraps to 0
        vecs[7] = '{4'b1001, 32'h7700_0066, 3'd3, 8'h77};  // ptr 1, skips to 3
        vecs[8] = '{4'b1010, 32'h8800_9900, 3'd1, 8'h99};  // ptr 0
        vecs[9] = '{4'b0001, 32'h0000_00C5, 3'd0, 8'hC5};  // ptr 2, wraps to 0

        rst = 1'b1;
        req_valid = '0; req_byte = '0; tx_active = 1'b0; tx_done = 1'b0;
        g_req_valid = '0; g_req_byte = '0; g_tx_active = 1'b0; g_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst ack",  32'(req_ack),  32'd0);
        chk("rst dv",   32'(tx_dv),    32'd0);
        chk("rst byte", 32'(tx_byte),  32'd0);
        chk("rst gid",  32'(grant_id), 32'd0);
        chk("rst busy", 32'(busy),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        for (int v = 0; v < 10; v++) begin
            do_txn(vecs[v].rv, vecs[v].rb, vecs[v].id, vecs[v].byt, $sformatf("v%0d", v));
        end
        // rr_ptr is now 1.

`ifdef UART_TAG_EN
        do_txn(4'b0010, 32'h0000_5500, 3'd1, 8'h55, "tag");
`else
        // Transmitter busy for 20 cycles; a stray tx_done meanwhile is ignored.
        tx_active = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        req_byte  = 32'h0000_5A00;
        @(negedge clk);
        chk("busy ack", 32'(req_ack),  32'h2);
        chk("busy gid", 32'(grant_id), 32'd1);
        req_valid = 4'b0000;
        dv_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tx_done = (c == 9);
            @(negedge clk);
            dv_seen = dv_seen | tx_dv;
        end
        tx_done = 1'b0;
        chk("busy no dv",   32'(dv_seen), 32'd0);
        chk("busy hold",    32'(busy),    32'd1);
        tx_active = 1'b0;
        @(negedge clk);
        chk("busy start",   32'(tx_dv),   32'd0);
        @(negedge clk);
        chk("busy dv",      32'(tx_dv),   32'd1);
        chk("busy byte",    32'(tx_byte), 32'h5A);
        finish_byte("busy");
        chk("busy end",     32'(busy),    32'd0);
        // rr_ptr is now 2.

        // Gap instance: same requester twice back to back.
        @(negedge clk);
        g_req_valid = 4'b0001;
        g_req_byte  = 32'h0000_00B7;
        @(negedge clk);
        chk("gap ack1", 32'(g_req_ack), 32'h1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_tx_dv && n < 50);
        chk("gap lat",  32'(n),         32'd2);
        chk("gap byte", 32'(g_tx_byte), 32'hB7);
        repeat (3) @(negedge clk);
        g_tx_done = 1'b1;
        @(negedge clk);
        g_tx_done = 1'b0;
        // 5 GAP cycles plus the arbitration cycle, then ack is visible.
        k = 1;
        while (g_req_ack == 4'b0000 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("gap rearb", 32'(k), 32'd7);
        g_req_valid = 4'b0000;

        // Asynchronous reset while waiting for tx_done.
        @(negedge clk);
        req_valid = 4'b0100;
        req_byte  = 32'h003C_0000;
        @(negedge clk);
        chk("mid ack", 32'(req_ack), 32'h4);
        req_valid = 4'b0000;
        wait_dv(n);
        chk("mid byte", 32'(tx_byte), 32'h3C);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst ack",  32'(req_ack),  32'd0);
        chk("arst dv",   32'(tx_dv),    32'd0);
        chk("arst byte", 32'(tx_byte),  32'd0);
        chk("arst gid",  32'(grant_id), 32'd0);
        chk("arst busy", 32'(busy),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_txn(4'b1000, 32'hE100_0000, 3'd3, 8'hE1, "post rst");
        @(negedge clk);
        chk("post rst ack0", 32'(req_ack), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
